// File: rtl/stroke_cmd_gen.sv
// rtl/stroke_cmd_gen.sv - touch samples to clipped brush-rectangle draw commands
//
// Purpose: joins successive pen-down touch samples with Bresenham stepping and
// stamps a square brush at every STRIDE-th pixel (the endpoint always), each stamp
// issued as one clipped rectangle command. A clear request issues a single
// full-screen rectangle in BG_COLOR.
// Ports:
//   clk_in, rst_n_in                    clock, asynchronous active-low reset
//   pt_x_in, pt_y_in, pen_down_in,
//   color_in, pt_valid_in, pt_ready_out touch sample handshake
//   clear_in                            one-cycle clear request pulse
//   draw_ready_in                       display can accept a command
//   col1_out, col2_out, row1_out,
//   row2_out, color_out, valid_out      rectangle command, valid_out one cycle
module stroke_cmd_gen #(
  parameter int         WIDTH    = 240,
  parameter int         HEIGHT   = 320,
  parameter int         BRUSH_R  = 2,
  parameter int         STRIDE   = 1,
  parameter logic [2:0] BG_COLOR = 3'b111
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] pt_x_in,
  input  logic [8:0] pt_y_in,
  input  logic       pen_down_in,
  input  logic [2:0] color_in,
  input  logic       pt_valid_in,
  output logic       pt_ready_out,
  input  logic       clear_in,
  input  logic       draw_ready_in,
  output logic [7:0] col1_out,
  output logic [7:0] col2_out,
  output logic [8:0] row1_out,
  output logic [8:0] row2_out,
  output logic [2:0] color_out,
  output logic       valid_out
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STEP, S_ISSUE, S_WAIT_ACK} state_t;

  localparam logic [7:0]        X_MAX       = 8'(WIDTH - 1);
  localparam logic [8:0]        Y_MAX       = 9'(HEIGHT - 1);
  localparam logic signed [9:0] R10         = 10'(BRUSH_R);
  localparam logic [7:0]        STRIDE_LAST = 8'(STRIDE - 1);

  state_t state, state_nxt;

  logic              have_last, clr_pend, is_clear, seen_low;
  logic [7:0]        last_x, cur_x, tgt_x, cap_x, step_x;
  logic [8:0]        last_y, cur_y, tgt_y, cap_y, step_y;
  logic [2:0]        stroke_color;
  logic [7:0]        stride_cnt;
  logic              sx, sy;
  logic signed [11:0] dx, dy, err, e2, step_err, ddx, ddy;
  logic              accept, same_pt, stride_hit, step_end, at_end;
  logic signed [9:0] xs, ys, x_lo, x_hi, y_lo, y_hi;
  logic [7:0]        brush_c1, brush_c2;
  logic [8:0]        brush_r1, brush_r2;

  assign cap_x      = (pt_x_in > X_MAX) ? X_MAX : pt_x_in;
  assign cap_y      = (pt_y_in > Y_MAX) ? Y_MAX : pt_y_in;
  assign accept     = pt_valid_in & pt_ready_out;
  assign same_pt    = (cap_x == last_x) && (cap_y == last_y);
  assign stride_hit = (stride_cnt == STRIDE_LAST);
  assign at_end     = (cur_x == tgt_x) && (cur_y == tgt_y);
  assign step_end   = (step_x == tgt_x) && (step_y == tgt_y);

  // Line setup: dx = |x1-x0|, dy = -|y1-y0| (all-octant error form).
  assign ddx = $signed({4'b0000, cap_x}) - $signed({4'b0000, last_x});
  assign ddy = $signed({3'b000, cap_y}) - $signed({3'b000, last_y});
  assign e2  = err <<< 1;

  always_comb begin
    step_x   = cur_x;
    step_y   = cur_y;
    step_err = err;
    if (e2 >= dy) begin
      step_err = step_err + dy;
      step_x   = sx ? cur_x + 8'd1 : cur_x - 8'd1;
    end
    if (e2 <= dx) begin
      step_err = step_err + dx;
      step_y   = sy ? cur_y + 9'd1 : cur_y - 9'd1;
    end
  end

  // Brush clipping in 10-bit signed so x-R / y+R never wrap at screen edges.
  always_comb begin
    xs       = $signed({2'b00, cur_x});
    ys       = $signed({1'b0, cur_y});
    x_lo     = xs - R10;
    x_hi     = xs + R10;
    y_lo     = ys - R10;
    y_hi     = ys + R10;
    brush_c1 = (x_lo < 10'sd0) ? 8'd0 : 8'(x_lo);
    brush_c2 = (x_hi > $signed({2'b00, X_MAX})) ? X_MAX : 8'(x_hi);
    brush_r1 = (y_lo < 10'sd0) ? 9'd0 : 9'(y_lo);
    brush_r2 = (y_hi > $signed({1'b0, Y_MAX})) ? Y_MAX : 9'(y_hi);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (clr_pend) state_nxt = S_CLEAR;
        else if (accept && pen_down_in)
          state_nxt = (!have_last || same_pt) ? S_ISSUE : S_STEP;
      end
      S_CLEAR:  state_nxt = S_ISSUE;
      S_STEP:   if (stride_hit || step_end) state_nxt = S_ISSUE;
      S_ISSUE:  if (draw_ready_in) state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        // Require a low-then-high on draw_ready_in so one stamp is never issued twice.
        if (seen_low && draw_ready_in)
          state_nxt = (!is_clear && !at_end) ? S_STEP : S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pt_ready_out = rst_n_in && (state == S_IDLE) && !clr_pend && !clear_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      have_last <= 1'b0; clr_pend <= 1'b0; is_clear <= 1'b0; seen_low <= 1'b0;
      last_x <= '0; last_y <= '0; cur_x <= '0; cur_y <= '0;
      tgt_x <= '0; tgt_y <= '0; stroke_color <= '0; stride_cnt <= '0;
      sx <= 1'b0; sy <= 1'b0; dx <= '0; dy <= '0; err <= '0;
      col1_out <= '0; col2_out <= '0; row1_out <= '0; row2_out <= '0;
      color_out <= '0; valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (state == S_CLEAR) clr_pend <= clear_in;
      else if (clear_in)    clr_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            stroke_color <= color_in;
            if (!pen_down_in) begin
              have_last <= 1'b0;
            end else begin
              tgt_x      <= cap_x;
              tgt_y      <= cap_y;
              stride_cnt <= '0;
              if (!have_last || same_pt) begin
                cur_x <= cap_x;
                cur_y <= cap_y;
              end else begin
                cur_x <= last_x;
                cur_y <= last_y;
                sx    <= (cap_x > last_x);
                sy    <= (cap_y > last_y);
                dx    <= (ddx < 12'sd0) ? -ddx : ddx;
                dy    <= (ddy < 12'sd0) ? ddy : -ddy;
                err   <= ((ddx < 12'sd0) ? -ddx : ddx) + ((ddy < 12'sd0) ? ddy : -ddy);
              end
            end
          end
        end
        S_CLEAR: begin
          is_clear  <= 1'b1;
          have_last <= 1'b0;
        end
        S_STEP: begin
          cur_x <= step_x;
          cur_y <= step_y;
          err   <= step_err;
          if (!(stride_hit || step_end)) stride_cnt <= stride_cnt + 8'd1;
        end
        S_ISSUE: begin
          if (draw_ready_in) begin
            col1_out  <= is_clear ? 8'd0 : brush_c1;
            col2_out  <= is_clear ? X_MAX : brush_c2;
            row1_out  <= is_clear ? 9'd0 : brush_r1;
            row2_out  <= is_clear ? Y_MAX : brush_r2;
            color_out <= is_clear ? BG_COLOR : stroke_color;
            valid_out <= 1'b1;
            seen_low  <= 1'b0;
          end
        end
        S_WAIT_ACK: begin
          if (!draw_ready_in) begin
            seen_low <= 1'b1;
          end else if (seen_low) begin
            if (is_clear) begin
              is_clear <= 1'b0;
            end else if (!at_end) begin
              stride_cnt <= '0;
            end else begin
              last_x    <= tgt_x;
              last_y    <= tgt_y;
              have_last <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stroke_cmd_gen.sv
// tb/tb_stroke_cmd_gen.sv - self-checking bench for stroke_cmd_gen
module tb_stroke_cmd_gen;
  localparam int W = 240;
  localparam int H = 320;
  localparam int R = 2;

  logic       clk_in = 1'b0, rst_n_in = 1'b0;
  logic [7:0] pt_x_in = '0;
  logic [8:0] pt_y_in = '0;
  logic       pen_down_in = 1'b0, pt_valid_in = 1'b0, clear_in = 1'b0;
  logic [2:0] color_in = '0;
  logic       draw_ready_in = 1'b1;
  logic       pt_ready_out, valid_out;
  logic [7:0] col1_out, col2_out;
  logic [8:0] row1_out, row2_out;
  logic [2:0] color_out;

  int tests_run = 0, tests_failed = 0, pulses = 0;
  logic [36:0] exp_q[$];
  bit m_have_last = 0;
  int m_lx = 0, m_ly = 0;
  bit force_low = 0;
  int busy = 0;

  stroke_cmd_gen dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .pt_x_in(pt_x_in), .pt_y_in(pt_y_in),
    .pen_down_in(pen_down_in), .color_in(color_in), .pt_valid_in(pt_valid_in),
    .pt_ready_out(pt_ready_out), .clear_in(clear_in), .draw_ready_in(draw_ready_in),
    .col1_out(col1_out), .col2_out(col2_out), .row1_out(row1_out), .row2_out(row2_out),
    .color_out(color_out), .valid_out(valid_out)
  );

  initial forever #5 clk_in = ~clk_in;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] rect(input int x, input int y, input logic [2:0] c);
    int x1, x2, y1, y2;
    x1 = (x - R < 0) ? 0 : x - R;
    x2 = (x + R > W - 1) ? W - 1 : x + R;
    y1 = (y - R < 0) ? 0 : y - R;
    y2 = (y + R > H - 1) ? H - 1 : y + R;
    return {8'(x1), 8'(x2), 9'(y1), 9'(y2), c};
  endfunction

  // Line from (x0,y0) to (x1,y1); start pixel excluded, every later pixel stamped.
  task automatic model_line(input int x0, input int y0, input int x1, input int y1,
                            input logic [2:0] c);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x1 > x0) ? 1 : -1;
    sy = (y1 > y0) ? 1 : -1;
    err = dx + dy; x = x0; y = y0;
    while (!(x == x1 && y == y1)) begin
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
      exp_q.push_back(rect(x, y, c));
    end
  endtask

  task automatic model_point(input int x, input int y, input bit pen, input logic [2:0] c);
    int cx, cy;
    cx = (x > W - 1) ? W - 1 : x;
    cy = (y > H - 1) ? H - 1 : y;
    if (!pen) m_have_last = 0;
    else begin
      if (!m_have_last || (cx == m_lx && cy == m_ly)) exp_q.push_back(rect(cx, cy, c));
      else model_line(m_lx, m_ly, cx, cy, c);
      m_lx = cx; m_ly = cy; m_have_last = 1;
    end
  endtask

  task automatic model_clear();
    exp_q.push_back({8'd0, 8'd239, 9'd0, 9'd319, 3'b111});
    m_have_last = 0;
  endtask

  // Display: drops ready for a few cycles after each command.
  initial begin
    forever begin
      @(negedge clk_in);
      if (force_low) draw_ready_in = 1'b0;
      else if (valid_out) begin draw_ready_in = 1'b0; busy = $urandom_range(1, 4); end
      else if (busy > 0) begin busy--; if (busy == 0) draw_ready_in = 1'b1; end
      else draw_ready_in = 1'b1;
    end
  end

  // Scoreboard: each pulse must match the oldest outstanding expected rectangle.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk_in);
      if (valid_out === 1'b1) begin
        pulses++;
        if (exp_q.size() == 0) chk("unexpected_pulse", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("cmd%0d", pulses),
              64'({col1_out, col2_out, row1_out, row2_out, color_out}), 64'(e));
        end
      end
    end
  end

  task automatic send_point(input int x, input int y, input bit pen, input logic [2:0] c);
    int n = 0;
    while (!pt_ready_out && n < 5000) begin @(negedge clk_in); n++; end
    if (!pt_ready_out) chk("send_ready_timeout", 64'(pt_ready_out), 64'd1);
    model_point(x, y, pen, c);
    pt_x_in = 8'(x); pt_y_in = 9'(y); pen_down_in = pen; color_in = c;
    pt_valid_in = 1'b1;
    @(negedge clk_in);
    pt_valid_in = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && pt_ready_out) && n < 8000) begin @(negedge clk_in); n++; end
    chk(tag, 64'(exp_q.size() == 0 && pt_ready_out), 64'd1);
    exp_q.delete();
  endtask

  initial begin
    int p0, ready_viol;
    repeat (2) @(negedge clk_in);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_ready", 64'(pt_ready_out), 64'd0);
    chk("rst_outputs", 64'({col1_out, col2_out, row1_out, row2_out, color_out}), 64'd0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("idle_ready", 64'(pt_ready_out), 64'd1);

    // Single stamp at (100,200) and first-stamp latency.
    p0 = pulses;
    send_point(100, 200, 1, 3'd5);
    chk("latency_n1", 64'(valid_out), 64'd0);
    wait_done("t1_done");
    chk("t1_count", 64'(pulses - p0), 64'd1);

    // Corner clipping and x clamp.
    send_point(0, 0, 0, 3'd0);
    send_point(0, 319, 1, 3'd2);
    wait_done("t2a_done");
    send_point(0, 0, 0, 3'd0);
    send_point(250, 100, 1, 3'd3);
    wait_done("t2b_done");

    // Short horizontal line: 5 stamps, start pixel stamped once.
    send_point(0, 0, 0, 3'd0);
    p0 = pulses;
    send_point(10, 10, 1, 3'd4);
    send_point(14, 10, 1, 3'd4);
    wait_done("t3_done");
    chk("t3_count", 64'(pulses - p0), 64'd5);

    // Clear, then next pen-down is a single stamp.
    pulse_clear(); model_clear();
    wait_done("t4_clear");
    p0 = pulses;
    send_point(30, 40, 1, 3'd1);
    wait_done("t4_single");
    chk("t4_count", 64'(pulses - p0), 64'd1);

    // Display stalled for 1000 cycles.
    send_point(0, 0, 0, 3'd0);
    force_low = 1;
    p0 = pulses; ready_viol = 0;
    send_point(120, 160, 1, 3'd6);
    repeat (1000) begin @(negedge clk_in); if (pt_ready_out) ready_viol++; end
    chk("t5_no_pulse", 64'(pulses - p0), 64'd0);
    chk("t5_ready_low", 64'(ready_viol), 64'd0);
    force_low = 0;
    wait_done("t5_done");
    chk("t5_count", 64'(pulses - p0), 64'd1);

    // Pen-up between two points breaks the line.
    send_point(10, 10, 1, 3'd2);
    send_point(50, 50, 0, 3'd2);
    p0 = pulses;
    send_point(50, 50, 1, 3'd2);
    wait_done("t6_done");
    chk("t6_count", 64'(pulses - p0), 64'd1);

    // Clear during a stroke runs after the line.
    send_point(20, 20, 1, 3'd3);
    send_point(60, 25, 1, 3'd3);
    repeat (10) @(negedge clk_in);
    pulse_clear(); model_clear();
    wait_done("mid_clear_done");

    // Clear and point in the same IDLE cycle: clear wins.
    clear_in = 1'b1; pt_valid_in = 1'b1; pen_down_in = 1'b1;
    pt_x_in = 8'd70; pt_y_in = 9'd70; color_in = 3'd1;
    #1 chk("sim_ready_low", 64'(pt_ready_out), 64'd0);
    @(negedge clk_in);
    clear_in = 1'b0; pt_valid_in = 1'b0;
    model_clear();
    wait_done("sim_clear_done");

    // Randomized strokes against the model.
    for (int i = 0; i < 20; i++) begin
      send_point($urandom_range(0, 255), $urandom_range(0, 340),
                 $urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)));
      wait_done($sformatf("rand%0d_done", i));
      if ($urandom_range(0, 7) == 0) begin
        pulse_clear(); model_clear();
        wait_done($sformatf("rand%0d_clear", i));
      end
    end

    // Reset mid-line aborts the line.
    send_point(0, 0, 0, 3'd0);
    send_point(0, 0, 1, 3'd5);
    send_point(200, 0, 1, 3'd5);
    p0 = pulses;
    while (pulses - p0 < 5 && exp_q.size() > 0) @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    chk("midrst_valid", 64'(valid_out), 64'd0);
    chk("midrst_ready", 64'(pt_ready_out), 64'd0);
    chk("midrst_outputs", 64'({col1_out, col2_out, row1_out, row2_out, color_out}), 64'd0);
    exp_q.delete(); m_have_last = 0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    p0 = pulses;
    repeat (300) @(negedge clk_in);
    chk("midrst_no_pulse", 64'(pulses - p0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
